// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: streams CPU pixel words into a frame-buffer window
// through a small FIFO, and can fill the whole window with one colour.
// Ports:
//   CLOCK_50, resetn          clock, async active-low reset
//   cpu_valid/cpu_data/ready  pixel word handshake from the processor
//   clr_start/clr_colour      request a window fill with a colour
//   fb_plot/fb_addr/fb_data   registered frame-buffer write port
//   busy/full/done            filling, window full, end-of-operation pulse
module fb_write_scheduler #(
    parameter int                ADDR_W = 17,
    parameter logic [ADDR_W-1:0] BASE   = 17'h057E4,
    parameter logic [ADDR_W-1:0] LIMIT  = 17'h0AFC8,
    parameter int                DEPTH  = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_data,
    output logic              cpu_ready,
    input  logic              clr_start,
    input  logic [31:0]       clr_colour,
    output logic              fb_plot,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_data,
    output logic              busy,
    output logic              full,
    output logic              done
);

    // DEPTH must be a power of two >= 2 so the indices wrap naturally.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_STREAM,
        S_CLEAR,
        S_FULL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [31:0]       r_colour;
    logic [31:0]       w_colour_nxt;
    logic              r_plot;
    logic              w_plot_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       r_data;
    logic [31:0]       w_data_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic [31:0]       r_mem [DEPTH];
    logic [IDX_W-1:0]  r_wr;
    logic [IDX_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_clr_go;
    logic              w_last;
    logic              w_in_clear;

    assign cpu_ready  = (r_cnt < CNT_W'(DEPTH)) && (r_state != S_FULL);
    assign w_push     = cpu_valid && cpu_ready;
    assign w_clr_go   = clr_start && (r_state != S_CLEAR);
    // A fill request wins over a pop on the same edge; the word stays queued.
    assign w_pop      = (r_state == S_STREAM) && (r_cnt != '0) && !clr_start;
    assign w_in_clear = (r_state == S_CLEAR);
    assign w_last     = (r_ptr == LIMIT);

    assign fb_plot = r_plot;
    assign fb_addr = r_addr;
    assign fb_data = r_data;
    assign busy    = (r_state == S_CLEAR);
    assign full    = (r_state == S_FULL);
    assign done    = r_done;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_STREAM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The three branches are mutually exclusive by construction.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_done_nxt   = 1'b0;
        unique case (1'b1)
            w_clr_go: begin
                w_state_nxt  = S_CLEAR;
                w_ptr_nxt    = BASE;
                w_colour_nxt = clr_colour;
            end
            w_pop: begin
                w_plot_nxt = 1'b1;
                w_addr_nxt = r_ptr;
                w_data_nxt = r_mem[r_rd];
                if (w_last) begin
                    w_state_nxt = S_FULL;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end
            w_in_clear: begin
                w_plot_nxt = 1'b1;
                w_addr_nxt = r_ptr;
                w_data_nxt = r_colour;
                if (w_last) begin
                    w_state_nxt = S_STREAM;
                    w_ptr_nxt   = BASE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_ptr    <= BASE;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_addr   <= BASE;
            r_data   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + IDX_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + IDX_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr] <= cpu_data;
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: randomized scoreboard bench for fb_write_scheduler.
// Expected writes are queued by stimulus; a negedge monitor compares them.
module tb_fb_write_scheduler;

    localparam int          ADDR_W = 17;
    localparam logic [16:0] BASE   = 17'h057E4;
    localparam logic [16:0] LIMIT  = 17'h0AFC8;
    localparam int          DEPTH  = 4;
    localparam int          WIN    = int'(LIMIT) - int'(BASE) + 1;

    logic        CLOCK_50;
    logic        resetn;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        clr_start;
    logic [31:0] clr_colour;
    logic        fb_plot;
    logic [16:0] fb_addr;
    logic [31:0] fb_data;
    logic        busy;
    logic        full;
    logic        done;

    fb_write_scheduler #(
        .ADDR_W(ADDR_W),
        .BASE  (BASE),
        .LIMIT (LIMIT),
        .DEPTH (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .clr_start (clr_start),
        .clr_colour(clr_colour),
        .fb_plot   (fb_plot),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .busy      (busy),
        .full      (full),
        .done      (done)
    );

    typedef struct packed {
        logic [16:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         m_e;
    int          wr_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          busy_cyc = 0;
    int          exp_done = 0;
    logic [16:0] m_ptr;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    // Window model: streamed words land at successive addresses.
    function automatic void exp_stream(logic [31:0] d);
        exp_q.push_back(wr_t'{a: m_ptr, d: d});
        if (m_ptr != LIMIT) m_ptr = m_ptr + 17'd1;
    endfunction

    function automatic void exp_clear(logic [31:0] c);
        for (int i = 0; i < WIN; i++)
            exp_q.push_back(wr_t'{a: BASE + 17'(i), d: c});
        m_ptr = BASE;
    endfunction

    always @(negedge CLOCK_50) begin
        if (resetn) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (fb_plot) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected write: addr %0h data %0h, none queued",
                             fb_addr, fb_data);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("write", {15'b0, fb_addr, fb_data}, {15'b0, m_e.a, m_e.d});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drain(input string nm, input int lim);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            tick();
            k++;
        end
        chk({nm, " pending writes"}, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int          n;
        int          k;
        int          acc;
        int          k0;
        bit          got;
        logic [31:0] w;
        logic [31:0] c;

        cpu_valid  = 1'b0;
        cpu_data   = '0;
        clr_start  = 1'b0;
        clr_colour = '0;
        resetn     = 1'b1;
        m_ptr      = BASE;
        #2 resetn  = 1'b0;
        #1;
        chk("rst fb_plot", fb_plot, 0);
        chk("rst fb_addr", fb_addr, BASE);
        chk("rst fb_data", fb_data, 0);
        chk("rst busy", busy, 0);
        chk("rst full", full, 0);
        chk("rst done", done, 0);
        chk("rst ready", cpu_ready, 1);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        tick();

        // Three back-to-back words; first write two cycles after accept.
        wr_cyc.delete();
        k0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            cpu_valid = 1'b1;
            cpu_data  = 32'hA1 + 32'(i);
            chk("A ready", cpu_ready, 1);
            exp_stream(cpu_data);
            tick();
        end
        cpu_valid = 1'b0;
        drain("A", 20);
        chk("A write count", wr_cyc.size(), 3);
        if (wr_cyc.size() >= 3) begin
            chk("A cycle0", wr_cyc[0], k0 + 1);
            chk("A cycle1", wr_cyc[1], k0 + 2);
            chk("A cycle2", wr_cyc[2], k0 + 3);
        end

        // Fill request on the edge a queued word would pop.
        w = $urandom;
        c = $urandom;
        cpu_valid = 1'b1;
        cpu_data  = w;
        chk("B ready", cpu_ready, 1);
        tick();
        cpu_valid  = 1'b0;
        clr_colour = c;
        clr_start  = 1'b1;
        tick();
        clr_start  = 1'b0;
        clr_colour = $urandom;
        exp_clear(c);
        exp_stream(w);
        exp_done++;
        drain("B", WIN + 100);
        chk("B done count", done_cnt, exp_done);
        chk("B busy", busy, 0);

        // Stream the rest of the window until it reports full.
        n = 0;
        k = 0;
        cpu_valid = 1'b1;
        while (n < WIN - 1 && k < WIN + 50) begin
            cpu_data = $urandom;
            if (cpu_ready) begin
                exp_stream(cpu_data);
                n++;
            end
            tick();
            k++;
        end
        cpu_valid = 1'b0;
        chk("C accepted", n, WIN - 1);
        chk("C cycles", k, WIN - 1);
        exp_done++;
        drain("C", 100);
        chk("C full", full, 1);
        chk("C busy", busy, 0);
        chk("C done count", done_cnt, exp_done);
        cpu_valid = 1'b1;
        cpu_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            chk("C ready in full", cpu_ready, 0);
            tick();
        end
        cpu_valid = 1'b0;
        repeat (3) tick();

        // Fill from FULL, offering six words while the fill runs.
        busy_cyc   = 0;
        clr_colour = 32'hFFFFFFFF;
        clr_start  = 1'b1;
        tick();
        clr_start = 1'b0;
        exp_clear(32'hFFFFFFFF);
        exp_done++;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cpu_valid = 1'b1;
            cpu_data  = $urandom;
            got = 1'b0;
            for (int j = 0; j < 8 && !got; j++) begin
                chk("D ready", cpu_ready, (acc < DEPTH) ? 1 : 0);
                if (cpu_ready) begin
                    exp_stream(cpu_data);
                    acc++;
                    got = 1'b1;
                end
                tick();
            end
        end
        cpu_valid = 1'b0;
        chk("D accepted", acc, DEPTH);
        drain("D", WIN + 100);
        chk("D busy cycles", busy_cyc, WIN);
        chk("D done count", done_cnt, exp_done);
        chk("D full", full, 0);
        chk("D ready", cpu_ready, 1);

        // Reset in the middle of a fill, right after address 06000.
        c = $urandom;
        clr_colour = c;
        clr_start  = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int a = int'(BASE); a <= 'h6000; a++)
            exp_q.push_back(wr_t'{a: 17'(a), d: c});
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(negedge CLOCK_50);
            #1;
            k++;
        end
        chk("E reached 06000", exp_q.size(), 0);
        exp_q.delete();
        resetn = 1'b0;
        #1;
        chk("E fb_plot", fb_plot, 0);
        chk("E fb_addr", fb_addr, BASE);
        chk("E busy", busy, 0);
        chk("E done", done, 0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        m_ptr  = BASE;
        tick();
        cpu_valid = 1'b1;
        cpu_data  = $urandom;
        chk("E ready", cpu_ready, 1);
        exp_stream(cpu_data);
        tick();
        cpu_valid = 1'b0;
        drain("E", 20);
        repeat (5) tick();
        chk("E done count", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame-buffer word-address width.
REQ-002 SHALL have parameter BASE, default 17'h057E4, first writable address (inclusive).
REQ-003 SHALL have parameter LIMIT, default 17'h0AFC8, last writable address (inclusive); BASE <= LIMIT required.
REQ-004 SHALL have parameter DEPTH, default 4, input FIFO depth in words (power of two).
REQ-005 SHALL have port CLOCK_50  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cpu_valid  input  1  processor offers a pixel word.
REQ-008 SHALL have port cpu_data  input  32  pixel word from the processor.
REQ-009 SHALL have port cpu_ready  output  1  word accepted when cpu_valid && cpu_ready at a rising edge.
REQ-010 SHALL have port clr_start  input  1  one-cycle request to fill the whole window.
REQ-011 SHALL have port clr_colour  input  32  fill value, sampled on the accepted clr_start edge.
REQ-012 SHALL have port fb_plot  output  1  frame-buffer write strobe, registered.
REQ-013 SHALL have port fb_addr  output  ADDR_W  frame-buffer write address, registered.
REQ-014 SHALL have port fb_data  output  32  frame-buffer write data, registered.
REQ-015 SHALL have port busy  output  1  high while state is CLEAR.
REQ-016 SHALL have port full  output  1  high while state is FULL.
REQ-017 SHALL have port done  output  1  one-cycle pulse at end of a clear or when the window fills.

Function
REQ-018 SHALL implement states STREAM, CLEAR, FULL; write pointer ptr (ADDR_W bits); DEPTH-entry FIFO with count.
REQ-019 SHALL drive cpu_ready = (FIFO count < DEPTH) && state != FULL, combinationally from registered state.
REQ-020 In STREAM, SHALL pop one FIFO word per cycle when non-empty; on the pop edge it SHALL register fb_plot=1, fb_addr=ptr, fb_data=word, and increment ptr.
REQ-021 SHALL give two-cycle latency: word accepted at edge k into an empty FIFO appears with fb_plot high in the cycle after edge k+1.
REQ-022 SHALL deassert fb_plot in any cycle with no pop and no fill write; fb_addr/fb_data hold their last values.
REQ-023 When a STREAM pop writes ptr==LIMIT, SHALL enter FULL on that edge and pulse done the following cycle; ptr then holds LIMIT.
REQ-024 In FULL, SHALL perform no pops; FIFO contents retained; only clr_start leaves FULL.
REQ-025 On clr_start in any state other than CLEAR, SHALL enter CLEAR, set ptr=BASE, latch clr_colour; clr_start during CLEAR SHALL be ignored.
REQ-026 In CLEAR, SHALL write latched colour at ptr every cycle (fb_plot=1), incrementing ptr from BASE to LIMIT, exactly LIMIT-BASE+1 writes.
REQ-027 After writing LIMIT in CLEAR, SHALL set ptr=BASE, return to STREAM, pulse done the next cycle.
REQ-028 FIFO SHALL keep accepting pushes during CLEAR (subject to REQ-019) and drain only after return to STREAM.
REQ-029 clr_start SHALL take priority over a STREAM pop on the same edge: no pop occurs, word stays in FIFO.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; ptr SHALL never exceed LIMIT or wrap.

Reset
REQ-031 On resetn low, SHALL asynchronously set state=STREAM, ptr=BASE, FIFO empty, fb_plot=0, fb_addr=BASE, fb_data=0, busy=0, full=0, done=0.
REQ-032 Reset asserted mid-CLEAR or mid-stream SHALL abort the operation, discard FIFO contents, and emit no done pulse.

Verification
REQ-033 Push 32'hA1,32'hA2,32'hA3 on consecutive edges after reset -> fb_plot high 3 consecutive cycles at addr 17'h057E4,057E5,057E6, first write two cycles after first accept.
REQ-034 Hold cpu_valid with fb side popping; stream 22501 words -> last write at 17'h0AFC8, full=1, done one pulse, cpu_ready=0 thereafter.
REQ-035 In FULL, pulse clr_start with clr_colour=32'hFFFFFFFF -> busy high 22501 cycles, every address 057E4..0AFC8 written once with FFFFFFFF, then done pulse, ptr=057E4, state STREAM.
REQ-036 Push 6 words during CLEAR -> exactly 4 accepted (cpu_ready drops), written to 057E4..057E7 after CLEAR ends.
REQ-037 clr_start and a pending pop on the same edge -> CLEAR entered, FIFO word retained and written to 057E4 after clear.
REQ-038 Drop resetn at fill address 17'h06000 -> fb_plot=0 immediately, no done, after release next push writes 17'h057E4.
